// File: rtl/div_pkg.sv
// Shared types and constants for the serial restoring divider.
package div_pkg;

  localparam int DIV_WIDTH = 8;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } state_t;

endpackage

// File: rtl/ripplesub.sv
// Parameterised borrow-ripple subtractor: diff = a - b - bin, bout = final borrow.
module ripplesub #(
  parameter int WIDTH = 9
) (
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic             bin,
  output logic [WIDTH-1:0] diff,
  output logic             bout
);

  logic [WIDTH:0] w_borrow;

  assign w_borrow[0] = bin;

  // One full-subtractor cell per bit; borrow ripples from LSB to MSB.
  for (genvar i = 0; i < WIDTH; i++) begin : g_cell
    assign diff[i]       = a[i] ^ b[i] ^ w_borrow[i];
    assign w_borrow[i+1] = (~a[i] & b[i]) | (~(a[i] ^ b[i]) & w_borrow[i]);
  end

  assign bout = w_borrow[WIDTH];

endmodule

// File: rtl/serial_divider.sv
// Unsigned restoring divider, one quotient bit per clock; zero divisor short-cuts to DONE.
module serial_divider
  import div_pkg::*;
#(
  parameter int WIDTH = DIV_WIDTH
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic [WIDTH-1:0] dividend,
  input  logic [WIDTH-1:0] divisor,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] quotient,
  output logic [WIDTH-1:0] remainder,
  output logic             div_by_zero,
  output state_t           dbg_state
);

  localparam int CW = $clog2(WIDTH) + 1;

  state_t           r_state;
  state_t           w_next;
  logic [WIDTH-1:0] r_work;   // dividend bits shift out of the top, quotient bits in at the bottom
  logic [WIDTH-1:0] r_dvs;
  logic [WIDTH:0]   r_part;
  logic [CW-1:0]    r_cnt;
  logic [WIDTH-1:0] r_quot;
  logic [WIDTH-1:0] r_rem;
  logic             r_dbz;

  logic [WIDTH:0]   w_shift;
  logic [WIDTH:0]   w_trial;
  logic             w_borrow;
  logic             w_qbit;
  logic [WIDTH:0]   w_part_nx;
  logic [WIDTH-1:0] w_work_nx;
  logic             w_last;

  assign w_shift = {r_part[WIDTH-1:0], r_work[WIDTH-1]};

  ripplesub #(
    .WIDTH(WIDTH + 1)
  ) u_sub (
    .a   (w_shift),
    .b   ({1'b0, r_dvs}),
    .bin (1'b0),
    .diff(w_trial),
    .bout(w_borrow)
  );

  assign w_qbit    = ~w_borrow;
  assign w_part_nx = w_borrow ? w_shift : w_trial;
  assign w_work_nx = {r_work[WIDTH-2:0], w_qbit};
  assign w_last    = (r_cnt == CW'(WIDTH - 1));

  always_comb begin
    w_next = r_state;
    case (r_state)
      IDLE:    if (start) w_next = (divisor == '0) ? DONE : RUN;
      RUN:     if (w_last) w_next = DONE;
      DONE:    w_next = IDLE;
      default: w_next = IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) r_state <= IDLE;
    else     r_state <= w_next;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_work <= '0;
      r_dvs  <= '0;
      r_part <= '0;
      r_cnt  <= '0;
      r_quot <= '0;
      r_rem  <= '0;
      r_dbz  <= 1'b0;
    end else begin
      case (r_state)
        IDLE: begin
          if (start && divisor != '0) begin
            r_work <= dividend;
            r_dvs  <= divisor;
            r_part <= '0;
            r_cnt  <= '0;
          end else if (start) begin
            r_quot <= '1;
            r_rem  <= dividend;
            r_dbz  <= 1'b1;
          end
        end
        RUN: begin
          r_part <= w_part_nx;
          r_work <= w_work_nx;
          r_cnt  <= r_cnt + CW'(1);
          if (w_last) begin
            r_quot <= w_work_nx;
            r_rem  <= w_part_nx[WIDTH-1:0];
            r_dbz  <= 1'b0;
          end
        end
        default: ;
      endcase
    end
  end

  assign busy        = (r_state == RUN);
  assign done        = (r_state == DONE);
  assign quotient    = r_quot;
  assign remainder   = r_rem;
  assign div_by_zero = r_dbz;
  assign dbg_state   = r_state;

endmodule

// File: tb/tb_serial_divider.sv
// Bench for serial_divider: arithmetic reference model, per-cycle compare, directed and random divisions.
module tb_serial_divider;
  import div_pkg::*;

  localparam int W  = 8;
  localparam int EW = 2 * W + 1;

  // ---------------- clock / reset ----------------
  logic         clk = 1'b0;
  logic         rst = 1'b1;
  logic         start = 1'b0;
  logic [W-1:0] dividend = '0;
  logic [W-1:0] divisor = '0;
  logic         busy, done, div_by_zero;
  logic [W-1:0] quotient, remainder;
  state_t       dbg_state;

  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  serial_divider #(.WIDTH(W)) dut (
    .clk        (clk),
    .rst        (rst),
    .start      (start),
    .dividend   (dividend),
    .divisor    (divisor),
    .busy       (busy),
    .done       (done),
    .quotient   (quotient),
    .remainder  (remainder),
    .div_by_zero(div_by_zero),
    .dbg_state  (dbg_state)
  );

  // ---------------- model / scoreboard state ----------------
  logic [EW-1:0]  exp_q[$];   // {div_by_zero, quotient, remainder}
  logic [2*W-1:0] op_q[$];    // {dividend, divisor}
  bit             m_active = 0;
  bit             m_zero = 0;
  int             m_e = 0;
  logic [W-1:0]   m_q = '0;
  logic [W-1:0]   m_r = '0;
  logic           m_z = 1'b0;
  int             done_lat = -1;
  int             busy_cnt = 0;
  int             n_checks = 0;
  int             n_fail = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0d expected %0d (t=%0t)", name, act, exp, $time);
    end
  endtask

  // ---------------- compare process ----------------
  always @(negedge clk) begin : compare
    logic           exp_busy;
    logic           exp_done;
    logic [EW-1:0]  e;
    logic [2*W-1:0] op;
    exp_busy = m_active && !m_zero && (cyc >= m_e) && (cyc < m_e + W);
    exp_done = m_active && (cyc == m_e + (m_zero ? 0 : W));
    if (exp_done) begin
      chk("exp_q_size", exp_q.size(), 1);
      if (exp_q.size() > 0) begin
        e  = exp_q.pop_front();
        op = op_q.pop_front();
        {m_z, m_q, m_r} = e;
        if (op[W-1:0] != '0) begin
          chk("identity", int'(quotient) * int'(op[W-1:0]) + int'(remainder), int'(op[2*W-1:W]));
          chk("rem_lt_div", remainder < op[W-1:0], 1);
        end
      end
      done_lat = cyc - m_e;
      m_active = 0;
    end
    if (busy) busy_cnt++;
    chk("busy", busy, exp_busy);
    chk("done", done, exp_done);
    chk("quotient", quotient, m_q);
    chk("remainder", remainder, m_r);
    chk("div_by_zero", div_by_zero, m_z);
  end

  // ---------------- driver tasks (called at posedge+2) ----------------
  task automatic wait_idle();
    int budget = 0;
    while (m_active && budget < 40) begin
      @(posedge clk); #2;
      budget++;
    end
    if (m_active) begin
      chk("idle_timeout", m_active, 0);
      m_active = 0;
      exp_q.delete();
      op_q.delete();
    end
  endtask

  task automatic launch(input logic [W-1:0] a, input logic [W-1:0] b);
    logic [W-1:0] q, r;
    wait_idle();
    start    = 1'b1;
    dividend = a;
    divisor  = b;
    if (b == '0) exp_q.push_back({1'b1, {W{1'b1}}, a});
    else begin
      q = a / b;
      r = a % b;
      exp_q.push_back({1'b0, q, r});
    end
    op_q.push_back({a, b});
    @(posedge clk); #1;
    m_e      = cyc;
    m_zero   = (b == '0);
    m_active = 1;
    busy_cnt = 0;
    done_lat = -1;
    start    = 1'b0;
    dividend = W'($urandom);
    divisor  = W'($urandom);
    #1;
  endtask

  task automatic check_lit(input string name, input int q, input int r, input int z,
                           input int lat, input int bcnt);
    wait_idle();
    chk({name, "_q"}, quotient, q);
    chk({name, "_r"}, remainder, r);
    chk({name, "_dbz"}, div_by_zero, z);
    chk({name, "_latency"}, done_lat, lat);
    chk({name, "_busy_cycles"}, busy_cnt, bcnt);
  endtask

  task automatic cycles(input int n);
    repeat (n) begin
      @(posedge clk); #2;
    end
  endtask

  // ---------------- stimulus ----------------
  initial begin : stim
    logic [W-1:0] a, b;
    cycles(2);
    chk("rst_state", dbg_state, IDLE);
    chk("rst_busy", busy, 0);
    chk("rst_done", done, 0);
    chk("rst_q", quotient, 0);
    chk("rst_r", remainder, 0);
    chk("rst_dbz", div_by_zero, 0);
    rst = 1'b0;
    cycles(1);

    launch(8'd100, 8'd7);   check_lit("100_7", 14, 2, 0, 8, 8);
    launch(8'd255, 8'd1);   check_lit("255_1", 255, 0, 0, 8, 8);
    launch(8'd255, 8'd255); check_lit("255_255", 1, 0, 0, 8, 8);
    launch(8'd5, 8'd9);     check_lit("5_9", 0, 5, 0, 8, 8);
    launch(8'd200, 8'd0);   check_lit("200_0", 255, 200, 1, 0, 0);
    launch(8'd0, 8'd3);     check_lit("0_3", 0, 0, 0, 8, 8);

    // start held high through RUN and DONE must not queue a second division
    launch(8'd100, 8'd7);
    cycles(1);
    start = 1'b1; dividend = 8'd50; divisor = 8'd5;
    cycles(8);
    start = 1'b0;
    check_lit("ignored", 14, 2, 0, 8, 8);
    launch(8'd50, 8'd5);    check_lit("50_5", 10, 0, 0, 8, 8);

    // reset in the 4th RUN cycle aborts without a done pulse
    launch(8'd100, 8'd7);
    cycles(3);
    m_active = 0;
    exp_q.delete();
    op_q.delete();
    m_q = '0; m_r = '0; m_z = 1'b0;
    rst = 1'b1;
    #1;
    chk("abort_busy", busy, 0);
    chk("abort_done", done, 0);
    chk("abort_q", quotient, 0);
    chk("abort_r", remainder, 0);
    chk("abort_state", dbg_state, IDLE);
    #1;
    cycles(1);
    rst = 1'b0;
    launch(8'd9, 8'd3);     check_lit("9_3", 3, 0, 0, 8, 8);

    for (int i = 0; i < 1500; i++) begin
      a = W'($urandom_range(0, 255));
      if (i % 25 == 0)     b = '0;
      else if (i % 5 == 0) b = W'($urandom_range(1, 4));
      else                 b = W'($urandom_range(1, 255));
      launch(a, b);
    end
    wait_idle();
    cycles(3);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

  initial begin : watchdog
    #1_000_000;
    $display("FAIL watchdog: simulation time limit reached at t=%0t", $time);
    $fatal(1, "watchdog");
  end

endmodule
